// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: shared opcodes, FSM states and helpers for the ALU result capture stage.
package alu_result_stage_pkg;
    localparam int REG_SIZE_DEF = 32;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_ROL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3] & op[2];
    endfunction
    function automatic logic is_muldiv(input logic [3:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction
endpackage

// File: rtl/alu_result_stage_settle.sv
// alu_settle_counter: loadable down-counter that stops at zero; done flags the final settle cycle.
module alu_settle_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end
    assign done = count == '0;
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures the 64-bit ALU result after a per-op settle time, holds it under
// valid/ready, and owns HI/LO. Optional z_zero/z_neg flags with `ALU_RESULT_FLAGS_EN.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int REG_SIZE      = REG_SIZE_DEF,
    parameter int SIMPLE_CYCLES = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [3:0]            ctrl_sig,
    input  logic [2*REG_SIZE-1:0] alu_c_in,
    output logic                  busy,
    output logic                  z_valid,
    input  logic                  z_ready,
    output logic [REG_SIZE-1:0]   z_hi,
    output logic [REG_SIZE-1:0]   z_lo,
    output logic                  z_err,
    output logic [REG_SIZE-1:0]   hi_q,
    output logic [REG_SIZE-1:0]   lo_q
`ifdef ALU_RESULT_FLAGS_EN
    ,
    output logic                  z_zero,
    output logic                  z_neg
`endif
);
    localparam int CW = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CW-1:0] SIMPLE_LD = CW'(SIMPLE_CYCLES - 1);
    localparam logic [CW-1:0] MULDIV_LD = CW'(MULDIV_CYCLES - 1);

    state_t state, state_nx;
    logic [3:0] op;
    logic load, capture, done;
    logic [REG_SIZE-1:0] cap_hi, cap_lo;

    alu_settle_counter #(.W(CW)) u_settle (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (load),
        .load_val (is_muldiv(ctrl_sig) ? MULDIV_LD : SIMPLE_LD),
        .done     (done)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                load     = start;
                state_nx = start ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                capture  = done;
                state_nx = done ? ST_HOLD : ST_SETTLE;
            end
            ST_HOLD: begin
                load     = z_ready & start;
                state_nx = z_ready ? (start ? ST_SETTLE : ST_IDLE) : ST_HOLD;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Only mul keeps the upper half; shift/add spill bits are dropped.
    assign cap_hi = op == OP_MUL ? alu_c_in[2*REG_SIZE-1:REG_SIZE] : '0;
    assign cap_lo = is_illegal(op) ? '0 : alu_c_in[REG_SIZE-1:0];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            op    <= '0;
            z_hi  <= '0;
            z_lo  <= '0;
            z_err <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nx;
            if (load)
                op <= ctrl_sig;
            if (capture) begin
                z_hi  <= cap_hi;
                z_lo  <= cap_lo;
                z_err <= is_illegal(op);
                if (op == OP_MUL)
                    hi_q <= cap_hi;
                if (op == OP_MUL || op == OP_DIV)
                    lo_q <= cap_lo;
            end
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            z_zero <= 1'b0;
            z_neg  <= 1'b0;
        end else if (capture) begin
            z_zero <= cap_lo == '0;
            z_neg  <= op == OP_MUL ? cap_hi[REG_SIZE-1] : cap_lo[REG_SIZE-1];
        end
    end
`endif

    assign busy    = state != ST_IDLE;
    assign z_valid = state == ST_HOLD;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: vector table, corner-case sequences and random ops against a reference model.
module tb_alu_result_stage;
    localparam int R = 32;

    logic clk = 1'b0, clr_n = 1'b0, start = 1'b0, z_ready = 1'b0;
    logic [3:0] ctrl_sig = '0;
    logic [2*R-1:0] alu_c_in = '0;
    logic busy, z_valid, z_err;
    logic [R-1:0] z_hi, z_lo, hi_q, lo_q;
`ifdef ALU_RESULT_FLAGS_EN
    logic z_zero, z_neg;
`endif

    alu_result_stage dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .ctrl_sig (ctrl_sig),
        .alu_c_in (alu_c_in),
        .busy     (busy),
        .z_valid  (z_valid),
        .z_ready  (z_ready),
        .z_hi     (z_hi),
        .z_lo     (z_lo),
        .z_err    (z_err),
        .hi_q     (hi_q),
        .lo_q     (lo_q)
`ifdef ALU_RESULT_FLAGS_EN
        ,
        .z_zero   (z_zero),
        .z_neg    (z_neg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] c;
        logic [31:0] zh, zl;
        logic        ze;
        logic [31:0] hq, lq;
    } vec_t;

    int errors = 0, checks = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cycles(input logic [3:0] op);
        return (op == 4'd8 || op == 4'd9) ? 4 : 1;
    endfunction

    function automatic void model(input logic [3:0] op, input logic [63:0] c,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ee);
        ee = op >= 4'd12;
        eh = op == 4'd8 ? 32'(c / 64'h1_0000_0000) : 32'd0;
        el = ee ? 32'd0 : 32'(c % 64'h1_0000_0000);
    endfunction

    task automatic issue(input logic [3:0] op, input logic [63:0] c);
        int lat;
        start    = 1'b1;
        ctrl_sig = op;
        alu_c_in = c;
        tick();
        start    = 1'b0;
        ctrl_sig = 4'($urandom);
        lat      = 1;
        while (!z_valid && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("latency op=%b", op), 64'(lat), 64'(cycles(op) + 1));
    endtask

    task automatic release_z(input int hold);
        z_ready = 1'b0;
        repeat (hold) begin
            tick();
            check("hold_valid", z_valid, 1);
        end
        z_ready = 1'b1;
        tick();
        z_ready = 1'b0;
        check("drop_valid", z_valid, 0);
        check("back_idle", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        logic [3:0] op;
        logic [63:0] c;
        logic [31:0] eh, el;
        logic ee;
        vt[0] = '{4'b0010, 64'h0000_0001_0000_0005, 32'h0, 32'h5,         1'b0, 32'h0, 32'h0};
        vt[1] = '{4'b1000, 64'h0000_0002_8000_0000, 32'h2, 32'h8000_0000, 1'b0, 32'h2, 32'h8000_0000};
        vt[2] = '{4'b1000, 64'h0000_0007_0000_0010, 32'h7, 32'h10,        1'b0, 32'h7, 32'h10};
        vt[3] = '{4'b1001, 64'hFFFF_FFFF_0000_0003, 32'h0, 32'h3,         1'b0, 32'h7, 32'h3};
        vt[4] = '{4'b1110, 64'hDEAD_BEEF_1234_5678, 32'h0, 32'h0,         1'b1, 32'h7, 32'h3};
        vt[5] = '{4'b0000, 64'h0000_0000_0F0F_0F0F, 32'h0, 32'h0F0F_0F0F, 1'b0, 32'h7, 32'h3};
        vt[6] = '{4'b1011, 64'h0000_0001_FFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'h7, 32'h3};
        vt[7] = '{4'b1111, 64'h1234_5678_9ABC_DEF0, 32'h0, 32'h0,         1'b1, 32'h7, 32'h3};
        vt[8] = '{4'b1010, 64'h0000_0000_0000_0000, 32'h0, 32'h0,         1'b0, 32'h7, 32'h3};

        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", z_valid, 0);
        check("rst_err", z_err, 0);
        check("rst_z", {z_hi, z_lo}, 0);
        check("rst_hilo", {hi_q, lo_q}, 0);
        clr_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            issue(vt[i].op, vt[i].c);
            check($sformatf("v%0d_zhi", i), z_hi, vt[i].zh);
            check($sformatf("v%0d_zlo", i), z_lo, vt[i].zl);
            check($sformatf("v%0d_zerr", i), z_err, vt[i].ze);
            check($sformatf("v%0d_hiq", i), hi_q, vt[i].hq);
            check($sformatf("v%0d_loq", i), lo_q, vt[i].lq);
            release_z(i % 3);
        end

        // Back-pressure, then handshake plus new start in the same cycle.
        issue(4'b0010, 64'hAA);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", z_valid, 1);
            check("bp_zlo", z_lo, 32'hAA);
        end
        z_ready  = 1'b1;
        start    = 1'b1;
        ctrl_sig = 4'b1011;
        alu_c_in = 64'hBB;
        tick();
        z_ready = 1'b0;
        start   = 1'b0;
        check("hs_valid_drop", z_valid, 0);
        check("hs_no_idle", busy, 1);
        tick();
        check("hs_next_valid", z_valid, 1);
        check("hs_next_zlo", z_lo, 32'hBB);
        release_z(0);

        // Illegal op with a second start while settling.
        start    = 1'b1;
        ctrl_sig = 4'b1110;
        alu_c_in = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        ctrl_sig = 4'b0010;
        alu_c_in = 64'h55;
        tick();
        start = 1'b0;
        check("ill_valid", z_valid, 1);
        check("ill_err", z_err, 1);
        check("ill_z", {z_hi, z_lo}, 0);
        release_z(2);

        m_hi = 32'h7;
        m_lo = 32'h3;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            c  = {$urandom, $urandom};
            issue(op, c);
            model(op, c, eh, el, ee);
            if (op == 4'd8) {m_hi, m_lo} = c;
            if (op == 4'd9) m_lo = c[31:0];
            check($sformatf("rnd%0d_zhi", i), z_hi, eh);
            check($sformatf("rnd%0d_zlo", i), z_lo, el);
            check($sformatf("rnd%0d_zerr", i), z_err, ee);
            check($sformatf("rnd%0d_hiq", i), hi_q, m_hi);
            check($sformatf("rnd%0d_loq", i), lo_q, m_lo);
`ifdef ALU_RESULT_FLAGS_EN
            check($sformatf("rnd%0d_zzero", i), z_zero, el == 0);
            check($sformatf("rnd%0d_zneg", i), z_neg, op == 4'd8 ? eh[31] : el[31]);
`endif
            release_z($urandom_range(0, 3));
        end

        // Async reset in the middle of a mul settle.
        start    = 1'b1;
        ctrl_sig = 4'b1000;
        alu_c_in = 64'h9_0000_0009;
        tick();
        start = 1'b0;
        tick();
        check("mid_busy", busy, 1);
        #2 clr_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", z_valid, 0);
        check("arst_err", z_err, 0);
        check("arst_z", {z_hi, z_lo}, 0);
        check("arst_hilo", {hi_q, lo_q}, 0);
        @(negedge clk);
        clr_n = 1'b1;
        tick();
        check("post_busy", busy, 0);
        check("post_valid", z_valid, 0);
        issue(4'b0010, 64'h5);
        check("post_zlo", z_lo, 32'h5);
        check("post_hilo", {hi_q, lo_q}, 0);
        release_z(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
